lvt_mpram: RTL and testbench

LVT_MPRAM -- requirements
Module: lvt_mpram

---
 rtl/lvt_mpram.sv | 157 +++++++++++++++
 tb/tb_lvt_mpram.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_mpram.sv
// Multi-ported RAM: NUM_WR x NUM_RD 1W1R banks steered by a live value table.
// Define LVT_MPRAM_WR_BYPASS_EN for write-first same-cycle same-address reads.
module lvt_mpram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 17,
    parameter int RD_LAT = 1,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD-1:0][AW-1:0]     raddr,
    input  logic [NUM_RD-1:0]             ren,
    output logic [NUM_RD-1:0][WIDTH-1:0]  rdata,
    output logic [NUM_RD-1:0]             rvalid,
    input  logic [NUM_WR-1:0][AW-1:0]     waddr,
    input  logic [NUM_WR-1:0]             wen,
    input  logic [NUM_WR-1:0][WIDTH-1:0]  wdata
);

    if (DEPTH < 2) begin : g_chk_depth
        $fatal(1, "lvt_mpram: DEPTH=%0d out of range", DEPTH);
    end
    if (WIDTH < 1) begin : g_chk_width
        $fatal(1, "lvt_mpram: WIDTH=%0d out of range", WIDTH);
    end
    if (RD_LAT < 1) begin : g_chk_rd_lat
        $fatal(1, "lvt_mpram: RD_LAT=%0d out of range", RD_LAT);
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_chk_num_rd
        $fatal(1, "lvt_mpram: NUM_RD=%0d out of range", NUM_RD);
    end
    if (NUM_WR < 1 || NUM_WR > 8) begin : g_chk_num_wr
        $fatal(1, "lvt_mpram: NUM_WR=%0d out of range", NUM_WR);
    end

    logic [WIDTH-1:0] mem [NUM_WR][NUM_RD][DEPTH];
    logic [LW-1:0]    lvt [DEPTH];

    logic [NUM_WR-1:0] wr_ok;
    logic [NUM_RD-1:0] rd_in;

    logic [LW-1:0]    s0_sel  [NUM_RD];
    logic [WIDTH-1:0] s0_word [NUM_RD][NUM_WR];

    logic [RD_LAT-1:0] p_vld  [NUM_RD];
    logic [LW-1:0]     p_sel  [NUM_RD][RD_LAT];
    logic [WIDTH-1:0]  p_word [NUM_RD][RD_LAT][NUM_WR];

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wen[w] && rst_n &&
                       ({1'b0, waddr[w]} < (AW+1)'(DEPTH));
        end
        for (int r = 0; r < NUM_RD; r++) begin
            rd_in[r] = {1'b0, raddr[r]} < (AW+1)'(DEPTH);
        end
    end

    // Out-of-range reads carry all-zero candidates so they return 0.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            s0_sel[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                s0_word[r][w] = '0;
            end
            if (rd_in[r]) begin
                s0_sel[r] = lvt[raddr[r]];
                for (int w = 0; w < NUM_WR; w++) begin
                    s0_word[r][w] = mem[w][r][raddr[r]];
                end
            end
`ifdef LVT_MPRAM_WR_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && waddr[w] == raddr[r]) begin
                    s0_word[r][w] = wdata[w];
                    s0_sel[r]     = LW'(w);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WR; w++) begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (wr_ok[w]) begin
                    mem[w][r][waddr[w]] <= wdata[w];
                end
            end
        end
    end

    // Ascending port order lets the highest-indexed writer win a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                lvt[a] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    lvt[waddr[w]] <= LW'(w);
                end
            end
        end
    end

    // Data fields load only behind a valid bit, so the tail holds its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_RD; r++) begin
                p_vld[r] <= '0;
                for (int k = 0; k < RD_LAT; k++) begin
                    p_sel[r][k] <= '0;
                    for (int w = 0; w < NUM_WR; w++) begin
                        p_word[r][k][w] <= '0;
                    end
                end
            end
        end else begin
            for (int r = 0; r < NUM_RD; r++) begin
                p_vld[r][0] <= ren[r];
                if (ren[r]) begin
                    p_sel[r][0] <= s0_sel[r];
                    for (int w = 0; w < NUM_WR; w++) begin
                        p_word[r][0][w] <= s0_word[r][w];
                    end
                end
                for (int k = 1; k < RD_LAT; k++) begin
                    p_vld[r][k] <= p_vld[r][k-1];
                    if (p_vld[r][k-1]) begin
                        p_sel[r][k] <= p_sel[r][k-1];
                        for (int w = 0; w < NUM_WR; w++) begin
                            p_word[r][k][w] <= p_word[r][k-1][w];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rvalid[r] = p_vld[r][RD_LAT-1];
            rdata[r]  = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (p_sel[r][RD_LAT-1] == LW'(w)) begin
                    rdata[r] = p_word[r][RD_LAT-1][w];
                end
            end
        end
    end

endmodule

// File: tb/tb_lvt_mpram.sv
// Scoreboard bench for lvt_mpram: a 2R2W RD_LAT=1 instance and a 4R3W RD_LAT=3 one.
// Expected data follows LVT_MPRAM_WR_BYPASS_EN when it is defined.
module tb_lvt_mpram;

    localparam int W    = 17;
    localparam int A_D  = 1000;
    localparam int A_AW = 10;
    localparam int A_R  = 2;
    localparam int A_WN = 2;
    localparam int A_L  = 1;
    localparam int B_D  = 64;
    localparam int B_AW = 6;
    localparam int B_R  = 4;
    localparam int B_WN = 3;
    localparam int B_L  = 3;

    typedef struct {
        bit             known;
        logic [W-1:0]   d;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [A_R-1:0][A_AW-1:0]  a_raddr = '0;
    logic [A_R-1:0]            a_ren = '0;
    logic [A_R-1:0][W-1:0]     a_rdata;
    logic [A_R-1:0]            a_rvalid;
    logic [A_WN-1:0][A_AW-1:0] a_waddr = '0;
    logic [A_WN-1:0]           a_wen = '0;
    logic [A_WN-1:0][W-1:0]    a_wdata = '0;

    logic [B_R-1:0][B_AW-1:0]  b_raddr = '0;
    logic [B_R-1:0]            b_ren = '0;
    logic [B_R-1:0][W-1:0]     b_rdata;
    logic [B_R-1:0]            b_rvalid;
    logic [B_WN-1:0][B_AW-1:0] b_waddr = '0;
    logic [B_WN-1:0]           b_wen = '0;
    logic [B_WN-1:0][W-1:0]    b_wdata = '0;

    exp_t         qa [A_R][$];
    exp_t         qb [B_R][$];
    logic [W-1:0] bka [A_WN][A_D];
    bit           kna [A_WN][A_D];
    int           lva [A_D];
    logic [W-1:0] bkb [B_WN][B_D];
    bit           knb [B_WN][B_D];
    int           lvb [B_D];

    lvt_mpram #(
        .DEPTH(A_D), .WIDTH(W), .RD_LAT(A_L),
        .NUM_RD(A_R), .NUM_WR(A_WN)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .raddr(a_raddr), .ren(a_ren),
        .rdata(a_rdata), .rvalid(a_rvalid),
        .waddr(a_waddr), .wen(a_wen), .wdata(a_wdata)
    );

    lvt_mpram #(
        .DEPTH(B_D), .WIDTH(W), .RD_LAT(B_L),
        .NUM_RD(B_R), .NUM_WR(B_WN)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .raddr(b_raddr), .ren(b_ren),
        .rdata(b_rdata), .rvalid(b_rvalid),
        .waddr(b_waddr), .wen(b_wen), .wdata(b_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    exp_t m_e;
    bit   m_ev;

    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int r = 0; r < A_R; r++) begin
                m_ev = qa[r].size() > 0 && qa[r][0].due == cyc;
                n_cmp++;
                if (a_rvalid[r] !== m_ev) begin
                    n_bad++;
                    $display("FAIL sb_a_rvalid[%0d] cyc %0d got %b want %b",
                             r, cyc, a_rvalid[r], m_ev);
                end
                if (m_ev) begin
                    m_e = qa[r].pop_front();
                    if (m_e.known) begin
                        n_cmp++;
                        if (a_rdata[r] !== m_e.d) begin
                            n_bad++;
                            $display("FAIL sb_a_rdata[%0d] cyc %0d got %h want %h",
                                     r, cyc, a_rdata[r], m_e.d);
                        end
                    end
                end
            end
            for (int r = 0; r < B_R; r++) begin
                m_ev = qb[r].size() > 0 && qb[r][0].due == cyc;
                n_cmp++;
                if (b_rvalid[r] !== m_ev) begin
                    n_bad++;
                    $display("FAIL sb_b_rvalid[%0d] cyc %0d got %b want %b",
                             r, cyc, b_rvalid[r], m_ev);
                end
                if (m_ev) begin
                    m_e = qb[r].pop_front();
                    if (m_e.known) begin
                        n_cmp++;
                        if (b_rdata[r] !== m_e.d) begin
                            n_bad++;
                            $display("FAIL sb_b_rdata[%0d] cyc %0d got %h want %h",
                                     r, cyc, b_rdata[r], m_e.d);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_a(
        input logic [A_R-1:0]            re,
        input logic [A_R-1:0][A_AW-1:0]  ra,
        input logic [A_WN-1:0]           we,
        input logic [A_WN-1:0][A_AW-1:0] wa,
        input logic [A_WN-1:0][W-1:0]    wd
    );
        exp_t e;
        @(negedge clk);
        a_ren = re; a_raddr = ra;
        a_wen = we; a_waddr = wa; a_wdata = wd;
        if (rst_n) begin
            for (int r = 0; r < A_R; r++) begin
                if (re[r]) begin
                    e.due = cyc + A_L;
                    if (int'(ra[r]) >= A_D) begin
                        e.known = 1'b1;
                        e.d = '0;
                    end else begin
                        e.known = kna[lva[ra[r]]][ra[r]];
                        e.d = bka[lva[ra[r]]][ra[r]];
                    end
`ifdef LVT_MPRAM_WR_BYPASS_EN
                    for (int w = 0; w < A_WN; w++) begin
                        if (we[w] && wa[w] == ra[r] && int'(wa[w]) < A_D) begin
                            e.known = 1'b1;
                            e.d = wd[w];
                        end
                    end
`endif
                    qa[r].push_back(e);
                end
            end
            for (int w = 0; w < A_WN; w++) begin
                if (we[w] && int'(wa[w]) < A_D) begin
                    bka[w][wa[w]] = wd[w];
                    kna[w][wa[w]] = 1'b1;
                    lva[wa[w]] = w;
                end
            end
        end
        @(posedge clk);
        #1;
        a_ren = '0; a_wen = '0;
    endtask

    task automatic drive_b(
        input logic [B_R-1:0]            re,
        input logic [B_R-1:0][B_AW-1:0]  ra,
        input logic [B_WN-1:0]           we,
        input logic [B_WN-1:0][B_AW-1:0] wa,
        input logic [B_WN-1:0][W-1:0]    wd
    );
        exp_t e;
        @(negedge clk);
        b_ren = re; b_raddr = ra;
        b_wen = we; b_waddr = wa; b_wdata = wd;
        if (rst_n) begin
            for (int r = 0; r < B_R; r++) begin
                if (re[r]) begin
                    e.due = cyc + B_L;
                    e.known = knb[lvb[ra[r]]][ra[r]];
                    e.d = bkb[lvb[ra[r]]][ra[r]];
`ifdef LVT_MPRAM_WR_BYPASS_EN
                    for (int w = 0; w < B_WN; w++) begin
                        if (we[w] && wa[w] == ra[r]) begin
                            e.known = 1'b1;
                            e.d = wd[w];
                        end
                    end
`endif
                    qb[r].push_back(e);
                end
            end
            for (int w = 0; w < B_WN; w++) begin
                if (we[w]) begin
                    bkb[w][wa[w]] = wd[w];
                    knb[w][wa[w]] = 1'b1;
                    lvb[wa[w]] = w;
                end
            end
        end
        @(posedge clk);
        #1;
        b_ren = '0; b_wen = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int r = 0; r < A_R; r++) begin
            n_cmp++;
            if (a_rvalid[r] !== 1'b0 || a_rdata[r] !== '0) begin
                n_bad++;
                $display("FAIL reset_a[%0d] got v=%b d=%h want v=0 d=0",
                         r, a_rvalid[r], a_rdata[r]);
            end
        end
        for (int r = 0; r < B_R; r++) begin
            n_cmp++;
            if (b_rvalid[r] !== 1'b0 || b_rdata[r] !== '0) begin
                n_bad++;
                $display("FAIL reset_b[%0d] got v=%b d=%h want v=0 d=0",
                         r, b_rvalid[r], b_rdata[r]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive_a('0, '0, 2'b01, {10'd0, 10'd5}, {17'd0, 17'h1AAAA});
        drive_a('0, '0, 2'b10, {10'd5, 10'd0}, {17'h00055, 17'd0});
        drive_a(2'b11, {10'd5, 10'd5}, '0, '0, '0);
        for (int r = 0; r < A_R; r++) begin
            n_cmp++;
            if (a_rvalid[r] !== 1'b1 || a_rdata[r] !== 17'h00055) begin
                n_bad++;
                $display("FAIL basic[%0d] got v=%b d=%h want v=1 d=00055",
                         r, a_rvalid[r], a_rdata[r]);
            end
        end
    endtask

    task automatic test_collision();
        drive_a('0, '0, 2'b11, {10'd7, 10'd7}, {17'h22, 17'h11});
        drive_a(2'b01, {10'd0, 10'd7}, '0, '0, '0);
        n_cmp++;
        if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 17'h22) begin
            n_bad++;
            $display("FAIL collision got v=%b d=%h want v=1 d=00022",
                     a_rvalid[0], a_rdata[0]);
        end
    endtask

    task automatic test_rd_wr_same();
        logic [W-1:0] want;
`ifdef LVT_MPRAM_WR_BYPASS_EN
        want = 17'hF0;
`else
        want = 17'h0F;
`endif
        drive_a('0, '0, 2'b01, {10'd0, 10'd3}, {17'd0, 17'h0F});
        drive_a(2'b01, {10'd0, 10'd3}, 2'b01, {10'd0, 10'd3}, {17'd0, 17'hF0});
        n_cmp++;
        if (a_rdata[0] !== want) begin
            n_bad++;
            $display("FAIL rd_wr_same got %h want %h", a_rdata[0], want);
        end
        drive_a(2'b01, {10'd0, 10'd3}, '0, '0, '0);
        n_cmp++;
        if (a_rdata[0] !== 17'hF0) begin
            n_bad++;
            $display("FAIL rd_after_wr got %h want 000f0", a_rdata[0]);
        end
    endtask

    task automatic test_hold();
        drive_a(2'b10, {10'd5, 10'd0}, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            drive_a('0, '0, 2'b01, {10'd0, 10'd5}, {17'd0, 17'h1234});
            n_cmp++;
            if (a_rvalid[1] !== 1'b0 || a_rdata[1] !== 17'h00055) begin
                n_bad++;
                $display("FAIL hold[%0d] got v=%b d=%h want v=0 d=00055",
                         i, a_rvalid[1], a_rdata[1]);
            end
        end
    endtask

    task automatic test_out_of_range();
        drive_a('0, '0, 2'b01, {10'd0, 10'd1010}, {17'd0, 17'h1FFFF});
        drive_a(2'b11, {10'd1010, 10'd1010}, '0, '0, '0);
        for (int r = 0; r < A_R; r++) begin
            n_cmp++;
            if (a_rvalid[r] !== 1'b1 || a_rdata[r] !== '0) begin
                n_bad++;
                $display("FAIL oob[%0d] got v=%b d=%h want v=1 d=0",
                         r, a_rvalid[r], a_rdata[r]);
            end
        end
    endtask

    task automatic test_distinct();
        drive_a('0, '0, 2'b11, {10'd20, 10'd21}, {17'h0ABCD, 17'h01234});
        drive_a(2'b11, {10'd20, 10'd21}, '0, '0, '0);
        n_cmp++;
        if (a_rdata[1] !== 17'h0ABCD || a_rdata[0] !== 17'h01234) begin
            n_bad++;
            $display("FAIL distinct got %h/%h want 0abcd/01234",
                     a_rdata[1], a_rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [A_R-1:0][A_AW-1:0]  ra;
        logic [A_WN-1:0][A_AW-1:0] wa;
        logic [A_WN-1:0][W-1:0]    wd;
        int pick [5] = '{3, 5, 7, 20, 21};
        for (int i = 0; i < 24; i++) begin
            for (int r = 0; r < A_R; r++) begin
                ra[r] = A_AW'(pick[$urandom_range(0, 4)]);
            end
            for (int w = 0; w < A_WN; w++) begin
                wa[w] = A_AW'(pick[$urandom_range(0, 4)]);
                wd[w] = W'($urandom);
            end
            drive_a(2'b11, ra, 2'b01, wa, wd);
            n_cmp++;
            if (a_rvalid !== 2'b11) begin
                n_bad++;
                $display("FAIL b2b_rvalid[%0d] got %b want 11", i, a_rvalid);
            end
        end
    endtask

    task automatic test_fill_b();
        for (int a = 0; a < B_D; a++) begin
            drive_b('0, '0, 3'b111,
                    {B_AW'(a), B_AW'(a), B_AW'(a)},
                    {W'($urandom), W'($urandom), W'($urandom)});
        end
    endtask

    task automatic test_latency();
        logic [7:0] ren_pat = 8'b0000_1011;
        logic [7:0] obs;
        logic [7:0] want;
        want = ren_pat << (B_L - 1);
        for (int k = 0; k < 8; k++) begin
            drive_b({3'b000, ren_pat[k]},
                    {6'd0, 6'd0, 6'd0, B_AW'(10 + k)}, '0, '0, '0);
            obs[k] = b_rvalid[0];
        end
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL latency_pattern got %b want %b", obs, want);
        end
    endtask

    task automatic test_reset_mid();
        drive_b(4'b1111, {6'd9, 6'd9, 6'd9, 6'd9}, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int r = 0; r < A_R; r++) qa[r].delete();
        for (int r = 0; r < B_R; r++) qb[r].delete();
        for (int a = 0; a < A_D; a++) lva[a] = 0;
        for (int a = 0; a < B_D; a++) lvb[a] = 0;
        #1;
        n_cmp++;
        if (b_rvalid !== '0 || b_rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_mid got v=%b d=%h want 0", b_rvalid, b_rdata);
        end
        drive_b('0, '0, 3'b001, {6'd0, 6'd0, 6'd2}, {17'd0, 17'd0, 17'h1FFFF});
        n_cmp++;
        if (b_rvalid !== '0 || b_rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_hold got v=%b d=%h want 0", b_rvalid, b_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_b('0, '0, '0, '0, '0);
            n_cmp++;
            if (b_rvalid !== '0) begin
                n_bad++;
                $display("FAIL reset_no_pulse[%0d] got %b want 0", i, b_rvalid);
            end
        end
        drive_b('0, '0, 3'b001, {6'd0, 6'd0, 6'd1}, {17'd0, 17'd0, 17'h3});
        drive_b(4'b0011, {6'd0, 6'd0, 6'd2, 6'd1}, '0, '0, '0);
        drive_b('0, '0, '0, '0, '0);
        drive_b('0, '0, '0, '0, '0);
        n_cmp++;
        if (b_rvalid[0] !== 1'b1 || b_rdata[0] !== 17'h3) begin
            n_bad++;
            $display("FAIL after_reset got v=%b d=%h want v=1 d=00003",
                     b_rvalid[0], b_rdata[0]);
        end
    endtask

    task automatic test_random();
        logic [B_R-1:0][B_AW-1:0]  ra;
        logic [B_WN-1:0][B_AW-1:0] wa;
        logic [B_WN-1:0][W-1:0]    wd;
        for (int i = 0; i < 10000; i++) begin
            for (int r = 0; r < B_R; r++) begin
                ra[r] = B_AW'($urandom_range(0, B_D - 1));
            end
            for (int w = 0; w < B_WN; w++) begin
                wa[w] = B_AW'($urandom_range(0, 15));
                wd[w] = W'($urandom);
            end
            drive_b(B_R'($urandom), ra, B_WN'($urandom), wa, wd);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < B_L + 2; i++) begin
            drive_b('0, '0, '0, '0, '0);
        end
        for (int r = 0; r < A_R; r++) begin
            n_cmp++;
            if (qa[r].size() != 0) begin
                n_bad++;
                $display("FAIL drain_a[%0d] got %0d pending want 0",
                         r, qa[r].size());
            end
        end
        for (int r = 0; r < B_R; r++) begin
            n_cmp++;
            if (qb[r].size() != 0) begin
                n_bad++;
                $display("FAIL drain_b[%0d] got %0d pending want 0",
                         r, qb[r].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_collision();
        test_rd_wr_same();
        test_hold();
        test_out_of_range();
        test_distinct();
        test_back_to_back();
        test_fill_b();
        test_latency();
        test_reset_mid();
        test_random();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
